// File: rtl/thickness_pkg.sv
// Shared definitions for the ultrasonic thickness front end.
//   state_t      : echo search state encoding
//   midscale_of  : offset-binary midscale for a given ADC sample width
package thickness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SEEK1,
    ST_PEAK1,
    ST_GAP,
    ST_SEEK2,
    ST_PEAK2,
    ST_DONE
  } state_t;

  // Offset-binary zero level: 2^(w-1). 512 for the 10-bit converter.
  function automatic int unsigned midscale_of(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/echo_peak_tracker.sv
// Peak candidate tracker for one echo window.
//   start    : crossing sample, loads it as candidate and opens the window
//   step     : further sample inside an open window
//   smp_amp  : rectified magnitude of the current sample
//   smp_idx  : index of the current sample
//   upd_amp  : candidate magnitude including the current sample
//   upd_idx  : candidate index including the current sample
//   win_done : the current sample is the last one of the window
module echo_peak_tracker
  import thickness_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int IDX_W    = 13,
  parameter int PEAK_WIN = 64
) (
  input  logic              clk_100,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] smp_amp,
  input  logic [IDX_W-1:0]  smp_idx,
  output logic [DATA_W-1:0] upd_amp,
  output logic [IDX_W-1:0]  upd_idx,
  output logic              win_done
);

  localparam int CNT_W = $clog2(PEAK_WIN + 1);

  logic [DATA_W-1:0] cand_amp;
  logic [IDX_W-1:0]  cand_idx;
  logic [CNT_W-1:0]  win_cnt;

  // Strictly-greater replace keeps the earliest index on ties.
  always_comb begin
    upd_amp  = cand_amp;
    upd_idx  = cand_idx;
    if (start || (step && (smp_amp > cand_amp))) begin
      upd_amp = smp_amp;
      upd_idx = smp_idx;
    end
    win_done = (start && (PEAK_WIN == 1)) ||
               (step && (win_cnt == CNT_W'(PEAK_WIN - 1)));
  end

  always_ff @(posedge clk_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      cand_amp <= '0;
      cand_idx <= '0;
      win_cnt  <= '0;
    end else if (start || step) begin
      cand_amp <= upd_amp;
      cand_idx <= upd_idx;
      win_cnt  <= start ? CNT_W'(1) : win_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/echo_peak_detect.sv
// Two-echo peak detector for one acquisition frame of ADC samples.
//   clk_100, RESET_N          : clock, asynchronous active-low reset
//   ad_data_valid             : frame level; rising edge starts a frame
//   sample_stb, ad_data       : sample strobe and offset-binary sample
//   threshold, blank_len,
//   min_gap                   : detection configuration, static per frame
//   busy                      : frame in progress
//   result_valid              : one-cycle pulse, results below held after it
//   echo1/2_idx, echo1/2_amp  : peak index and rectified magnitude per echo
//   delta_idx                 : echo2_idx - echo1_idx when both found
//   echo_flags                : bit0 echo 1 found, bit1 echo 2 found
module echo_peak_detect
  import thickness_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int IDX_W    = 13,
  parameter int PEAK_WIN = 64
) (
  input  logic              clk_100,
  input  logic              RESET_N,
  input  logic              ad_data_valid,
  input  logic              sample_stb,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic [IDX_W-1:0]  blank_len,
  input  logic [IDX_W-1:0]  min_gap,
  output logic              busy,
  output logic              result_valid,
  output logic [IDX_W-1:0]  echo1_idx,
  output logic [IDX_W-1:0]  echo2_idx,
  output logic [DATA_W-1:0] echo1_amp,
  output logic [DATA_W-1:0] echo2_amp,
  output logic [IDX_W-1:0]  delta_idx,
  output logic [1:0]        echo_flags
);

  localparam logic signed [DATA_W:0] MID = $signed((DATA_W+1)'(midscale_of(DATA_W)));
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  function automatic logic [DATA_W-1:0] rectify(input logic [DATA_W-1:0] smp);
    logic signed [DATA_W:0] diff;
    logic [DATA_W:0]        absd;
    diff = $signed({1'b0, smp}) - MID;
    absd = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    return absd[DATA_W] ? '1 : absd[DATA_W-1:0];
  endfunction

  state_t            st, st_nxt, eff;
  logic              ad_data_valid_p0;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    seek2_start;
  logic [IDX_W-1:0]  e1_idx;
  logic [DATA_W-1:0] e1_amp;
  logic [DATA_W-1:0] mag;
  logic              active, q, hit, trk_start, trk_step, win_done;
  logic              p1_open, p2_open, frame_end, e1_close;
  logic [DATA_W-1:0] upd_amp;
  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  rep_i1, rep_i2, rep_d;
  logic [DATA_W-1:0] rep_a1, rep_a2;
  logic [1:0]        rep_f;

  echo_peak_tracker #(
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W),
    .PEAK_WIN(PEAK_WIN)
  ) u_tracker (
    .clk_100 (clk_100),
    .RESET_N (RESET_N),
    .start   (trk_start),
    .step    (trk_step),
    .smp_amp (mag),
    .smp_idx (idx),
    .upd_amp (upd_amp),
    .upd_idx (upd_idx),
    .win_done(win_done)
  );

  assign busy = (st != ST_IDLE) && (st != ST_DONE);

  always_ff @(posedge clk_100 or negedge RESET_N) begin
    if (!RESET_N) st <= ST_IDLE;
    else          st <= st_nxt;
  end

  // BLANK and GAP are left by comparing the running index against their end,
  // so the sample that ends them is evaluated as a search sample (eff).
  always_comb begin
    mag       = rectify(ad_data);
    hit       = (mag >= threshold);
    active    = (st != ST_IDLE) && (st != ST_DONE);
    q         = sample_stb && ad_data_valid && active;
    eff       = st;
    if ((st == ST_BLANK) && (idx >= blank_len))          eff = ST_SEEK1;
    if ((st == ST_GAP) && ({1'b0, idx} >= seek2_start)) eff = ST_SEEK2;
    trk_start = q && hit && ((eff == ST_SEEK1) || (eff == ST_SEEK2));
    trk_step  = q && ((eff == ST_PEAK1) || (eff == ST_PEAK2));
    p1_open   = (eff == ST_PEAK1) || ((eff == ST_SEEK1) && trk_start);
    p2_open   = (eff == ST_PEAK2) || ((eff == ST_SEEK2) && trk_start);
    // Last index wins over any transition the same sample would cause.
    frame_end = active && (!ad_data_valid || (q && (idx == IDX_MAX)) ||
                           (q && p2_open && win_done));
    e1_close  = q && p1_open && win_done && !frame_end;

    st_nxt = st;
    case (st)
      ST_IDLE: if (ad_data_valid && !ad_data_valid_p0) st_nxt = ST_BLANK;
      ST_DONE: st_nxt = ST_IDLE;
      default: begin
        if (frame_end) begin
          st_nxt = ST_DONE;
        end else if (q) begin
          if (p1_open)      st_nxt = win_done ? ((min_gap == '0) ? ST_SEEK2 : ST_GAP) : ST_PEAK1;
          else if (p2_open) st_nxt = ST_PEAK2;
          else              st_nxt = eff;
        end
      end
    endcase

    rep_i1 = '0;
    rep_a1 = '0;
    rep_i2 = '0;
    rep_a2 = '0;
    rep_f  = 2'b00;
    if (p1_open) begin
      rep_i1 = upd_idx;
      rep_a1 = upd_amp;
      rep_f[0] = 1'b1;
    end else if ((st == ST_GAP) || (st == ST_SEEK2) || (st == ST_PEAK2)) begin
      rep_i1 = e1_idx;
      rep_a1 = e1_amp;
      rep_f[0] = 1'b1;
    end
    if (p2_open) begin
      rep_i2 = upd_idx;
      rep_a2 = upd_amp;
      rep_f[1] = 1'b1;
    end
    rep_d = (rep_f == 2'b11) ? (rep_i2 - rep_i1) : '0;
  end

  always_ff @(posedge clk_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      // Held high so a level already present at release is not a frame start.
      ad_data_valid_p0 <= 1'b1;
      idx              <= '0;
      seek2_start      <= '0;
      e1_idx           <= '0;
      e1_amp           <= '0;
      result_valid     <= 1'b0;
      echo1_idx        <= '0;
      echo1_amp        <= '0;
      echo2_idx        <= '0;
      echo2_amp        <= '0;
      delta_idx        <= '0;
      echo_flags       <= 2'b00;
    end else begin
      ad_data_valid_p0 <= ad_data_valid;
      result_valid     <= frame_end;
      if ((st == ST_IDLE) && (st_nxt == ST_BLANK)) idx <= '0;
      else if (q && !frame_end)                   idx <= idx + IDX_W'(1);
      if (e1_close) begin
        e1_idx      <= upd_idx;
        e1_amp      <= upd_amp;
        seek2_start <= {1'b0, idx} + (IDX_W+1)'(1) + {1'b0, min_gap};
      end
      if (frame_end) begin
        echo1_idx  <= rep_i1;
        echo1_amp  <= rep_a1;
        echo2_idx  <= rep_i2;
        echo2_amp  <= rep_a2;
        delta_idx  <= rep_d;
        echo_flags <= rep_f;
      end
    end
  end

endmodule

// File: tb/tb_echo_peak_detect.sv
module tb_echo_peak_detect;

  localparam int DATA_W   = 10;
  localparam int IDX_W    = 13;
  localparam int PEAK_WIN = 64;

  logic              clk_100 = 1'b0;
  logic              RESET_N;
  logic              ad_data_valid;
  logic              sample_stb;
  logic [DATA_W-1:0] ad_data;
  logic [DATA_W-1:0] threshold;
  logic [IDX_W-1:0]  blank_len;
  logic [IDX_W-1:0]  min_gap;
  logic              busy;
  logic              result_valid;
  logic [IDX_W-1:0]  echo1_idx, echo2_idx, delta_idx;
  logic [DATA_W-1:0] echo1_amp, echo2_amp;
  logic [1:0]        echo_flags;

  always #5 clk_100 = ~clk_100;

  echo_peak_detect #(
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W),
    .PEAK_WIN(PEAK_WIN)
  ) dut (
    .clk_100      (clk_100),
    .RESET_N      (RESET_N),
    .ad_data_valid(ad_data_valid),
    .sample_stb   (sample_stb),
    .ad_data      (ad_data),
    .threshold    (threshold),
    .blank_len    (blank_len),
    .min_gap      (min_gap),
    .busy         (busy),
    .result_valid (result_valid),
    .echo1_idx    (echo1_idx),
    .echo2_idx    (echo2_idx),
    .echo1_amp    (echo1_amp),
    .echo2_amp    (echo2_amp),
    .delta_idx    (delta_idx),
    .echo_flags   (echo_flags)
  );

  typedef struct {
    int i1; int a1; int i2; int a2; int d; int f;
  } res_t;

  typedef struct {
    int   bl; int thr; int mg; int n;
    int   pi [6];
    int   pv [6];
    res_t ex;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  res_t cap;
  int   stim [8192];
  vec_t vt [8];

  // Result capture on every result_valid pulse, away from the active edge.
  always @(negedge clk_100) begin
    if (result_valid) begin
      pulses <= pulses + 1;
      cap    <= '{int'(echo1_idx), int'(echo1_amp), int'(echo2_idx),
                  int'(echo2_amp), int'(delta_idx), int'(echo_flags)};
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk_100);
    #1;
  endtask

  task automatic strobe(input int d);
    ad_data    = DATA_W'(d);
    sample_stb = 1'b1;
    @(posedge clk_100);
    #1;
    sample_stb = 1'b0;
  endtask

  function automatic int magof(input int d);
    return (d >= 512) ? d - 512 : 512 - d;
  endfunction

  // Reference: scan the delivered samples of a frame by the detection rules.
  function automatic res_t model(input int n, input int bl, input int thr, input int mg);
    res_t r;
    int   start, c, best, last;
    r = '{0, 0, 0, 0, 0, 0};
    start = bl;
    for (int e = 0; e < 2; e++) begin
      c = -1;
      for (int k = start; k < n; k++) begin
        if (magof(stim[k]) >= thr) begin
          c = k;
          break;
        end
      end
      if (c < 0) break;
      best = c;
      last = c + PEAK_WIN - 1;
      if (last > n - 1) last = n - 1;
      for (int k = c; k <= last; k++)
        if (magof(stim[k]) > magof(stim[best])) best = k;
      if (e == 0) begin
        r.i1 = best; r.a1 = magof(stim[best]); r.f = 1;
      end else begin
        r.i2 = best; r.a2 = magof(stim[best]); r.f = r.f | 2;
      end
      start = c + PEAK_WIN + mg;
    end
    if (r.f == 3) r.d = r.i2 - r.i1;
    return r;
  endfunction

  task automatic run_frame(input string nm, input int bl, input int thr, input int mg,
                           input int n, input bit gaps, input res_t ex);
    int p0;
    blank_len = IDX_W'(bl);
    threshold = DATA_W'(thr);
    min_gap   = IDX_W'(mg);
    // Strobes before the frame opens must not advance the index.
    strobe(0);
    strobe(1023);
    ad_data_valid = 1'b1;
    cyc(2);
    p0 = pulses;
    for (int k = 0; k < n; k++) begin
      strobe(stim[k]);
      if (k == 8191) begin
        chk({nm, ".rv_after_last"}, int'(result_valid), 1);
        chk({nm, ".busy_after_last"}, int'(busy), 0);
        cyc(1);
        chk({nm, ".rv_one_cycle"}, int'(result_valid), 0);
      end else if (gaps && ($urandom_range(0, 1) == 1)) begin
        cyc(1);
      end
    end
    ad_data_valid = 1'b0;
    cyc(4);
    chk({nm, ".pulses"}, pulses - p0, 1);
    chk({nm, ".i1"}, cap.i1, ex.i1);
    chk({nm, ".a1"}, cap.a1, ex.a1);
    chk({nm, ".i2"}, cap.i2, ex.i2);
    chk({nm, ".a2"}, cap.a2, ex.a2);
    chk({nm, ".delta"}, cap.d, ex.d);
    chk({nm, ".flags"}, cap.f, ex.f);
    chk({nm, ".held_i1"}, int'(echo1_idx), ex.i1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t ex;
    int   p0, n, bl, thr, mg;

    vt[0] = '{10, 100, 50, 400, '{20, 21, 22, 25, 300, -1}, '{612, 612, 612, 700, 800, 0},
              '{25, 188, 300, 288, 275, 3}};
    vt[1] = '{0, 100, 0, 200, '{40, 45, -1, -1, -1, -1}, '{662, 362, 0, 0, 0, 0},
              '{40, 150, 0, 0, 0, 1}};
    vt[2] = '{0, 100, 0, 500, '{-1, -1, -1, -1, -1, -1}, '{0, 0, 0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 0}};
    vt[3] = '{0, 300, 0, 120, '{30, -1, -1, -1, -1, -1}, '{100, 0, 0, 0, 0, 0},
              '{30, 412, 0, 0, 0, 1}};
    vt[4] = '{5, 50, 0, 200, '{4, 5, 69, -1, -1, -1}, '{1000, 600, 400, 0, 0, 0},
              '{69 - 64, 88, 69, 112, 64, 3}};
    vt[5] = '{0, 50, 10, 300, '{0, 64, 73, 74, -1, -1}, '{600, 1023, 1000, 450, 0, 0},
              '{0, 88, 74, 62, 74, 3}};
    vt[6] = '{0, 50, 100, 150, '{10, 73, 74, -1, -1, -1}, '{600, 700, 1023, 0, 0, 0},
              '{73, 188, 0, 0, 0, 1}};
    vt[7] = '{0, 50, 0, 110, '{100, 105, -1, -1, -1, -1}, '{600, 650, 0, 0, 0, 0},
              '{105, 138, 0, 0, 0, 1}};

    RESET_N       = 1'b0;
    ad_data_valid = 1'b0;
    sample_stb    = 1'b0;
    ad_data       = '0;
    threshold     = '0;
    blank_len     = '0;
    min_gap       = '0;
    cyc(3);
    chk("rst.result_valid", int'(result_valid), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.echo1_idx", int'(echo1_idx), 0);
    chk("rst.echo2_amp", int'(echo2_amp), 0);
    chk("rst.delta", int'(delta_idx), 0);
    chk("rst.flags", int'(echo_flags), 0);
    RESET_N = 1'b1;
    cyc(2);

    // Directed frames from the vector table.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 8192; k++) stim[k] = 512;
      for (int p = 0; p < 6; p++)
        if (vt[v].pi[p] >= 0) stim[vt[v].pi[p]] = vt[v].pv[p];
      run_frame($sformatf("vec%0d", v), vt[v].bl, vt[v].thr, vt[v].mg, vt[v].n, 1'b0, vt[v].ex);
    end

    // Crossing near the end of the frame, peak on the very last index.
    for (int k = 0; k < 8192; k++) stim[k] = 512;
    for (int k = 0; k < 12; k++) stim[8180 + k] = 612 + 10 * k;
    run_frame("maxidx", 0, 100, 0, 8192, 1'b0, '{8191, 210, 0, 0, 0, 1});

    // Reset in the middle of an open echo-1 window.
    for (int k = 0; k < 8192; k++) stim[k] = 512;
    stim[40] = 700;
    blank_len = '0;
    threshold = DATA_W'(100);
    min_gap   = '0;
    ad_data_valid = 1'b1;
    cyc(2);
    p0 = pulses;
    for (int k = 0; k < 45; k++) strobe(stim[k]);
    chk("abort.busy_before", int'(busy), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.result_valid", int'(result_valid), 0);
    chk("abort.echo1_idx", int'(echo1_idx), 0);
    chk("abort.flags", int'(echo_flags), 0);
    ad_data_valid = 1'b0;
    cyc(3);
    RESET_N = 1'b1;
    cyc(4);
    chk("abort.no_pulse", pulses - p0, 0);
    for (int k = 0; k < 8192; k++) stim[k] = 512;
    stim[50] = 300;
    run_frame("restart", 0, 100, 0, 150, 1'b0, '{50, 212, 0, 0, 0, 1});

    // Randomized frames against the reference scan.
    for (int r = 0; r < 10; r++) begin
      n   = $urandom_range(50, 700);
      bl  = $urandom_range(0, 40);
      thr = $urandom_range(60, 300);
      mg  = $urandom_range(0, 60);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 29) == 0) stim[k] = $urandom_range(0, 1023);
        else                            stim[k] = 472 + $urandom_range(0, 80);
      end
      ex = model(n, bl, thr, mg);
      run_frame($sformatf("rnd%0d", r), bl, thr, mg, n, 1'b1, ex);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
